lfsr_keystream: RTL and testbench
=================================

LFSR_KEYSTREAM -- requirements
Module: lfsr_keystream

Interface
REQ-001 Parameter WIDTH, default 89: shift-register length in bits, range 4..256.
REQ-002 Parameter TAP_MASK, default (1<<0)|(1<<51): feedback taps, bit i set means reg[i] is XORed into feedback.
REQ-003 Parameter OUT_W, default 1: keystream bits produced per accepted beat, range 1..8.
REQ-004 Parameter WARMUP, default 160: free-running steps after load with output discarded, range 0..65535.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  single-cycle request to begin seed load; honoured only in IDLE.
REQ-008 stop  in  1  abort; forces IDLE from any state.
REQ-009 seed_bit  in  1  serial seed data.
REQ-010 seed_valid  in  1  seed_bit is valid.
REQ-011 seed_ready  out  1  high only in LOAD.
REQ-012 out_data  out  OUT_W  keystream beat; out_data[0] is the earliest bit.
REQ-013 out_valid  out  1  high only in RUN.
REQ-014 out_ready  in  1  consumer accepts the beat.
REQ-015 busy  out  1  high in LOAD, WARMUP and RUN.
REQ-016 err_zero  out  1  one-cycle pulse: loaded state was all-zero.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, WARMUP and RUN.
REQ-018 One LFSR step: fb = parity(reg & TAP_MASK); reg <= {fb, reg[WIDTH-1:1]}; the output bit of the step is the pre-step reg[0].
REQ-019 IDLE: start=1 -> LOAD, load counter cleared to 0; other inputs ignored.
REQ-020 LOAD: each cycle with seed_valid=1 shifts reg <= {seed_bit, reg[WIDTH-1:1]} and increments the load counter; no feedback is applied; seed_valid=0 holds state.
REQ-021 LOAD: on the cycle the WIDTHth bit is accepted, the FSM SHALL go to WARMUP, or to RUN if WARMUP=0; the first accepted bit ends in reg[0].
REQ-022 Zero-state check on LOAD exit: if the post-load reg equals 0, the FSM SHALL go to IDLE and pulse err_zero in the following cycle.
REQ-023 WARMUP: exactly one LFSR step per cycle for WARMUP cycles, then RUN; out_valid=0 throughout.
REQ-024 RUN: out_data[i] = output bit of step i of OUT_W consecutive steps from the current reg (unrolled combinationally), with out_valid=1.
REQ-025 RUN: when out_valid and out_ready are both high, reg advances OUT_W steps in one cycle; otherwise reg and out_data are held stable (no data loss under backpressure).
REQ-026 RUN persists until stop or reset; the sequence wraps naturally at the LFSR period with no special handling.
REQ-027 stop=1 in any state -> IDLE next cycle; reg cleared to 0; counters cleared; stop takes priority over start, seed and handshake on the same cycle.
REQ-028 start=1 outside IDLE SHALL be ignored.
REQ-029 Load and warmup counters SHALL be sized ceil(log2(max+1)) and never wrap.

Reset
REQ-030 reset=1 SHALL force IDLE, reg=0, all counters=0, seed_ready=0, out_valid=0, busy=0, err_zero=0, out_data=0; reset overrides stop and start.
REQ-031 Reset asserted mid-LOAD, mid-WARMUP or mid-RUN discards all progress; a new start is required afterwards.

Verification
REQ-032 WIDTH=4, TAP_MASK=4'b0011, WARMUP=0, OUT_W=1: start, seed 1,0,0,0 -> RUN with reg=4'b0001; accepted outputs 1,0,0,0,1,0,0,1; period 15.
REQ-033 Same config with OUT_W=4 -> first beat out_data=4'b0001, second beat 4'b1001.
REQ-034 Same config with out_ready held low for 5 cycles in RUN -> out_data constant and reg unchanged; stream resumes without skipped bits.
REQ-035 Seed 0,0,0,0 -> no RUN entry, return to IDLE, err_zero high exactly one cycle, out_valid never asserted.
REQ-036 Defaults (WIDTH=89, WARMUP=160): seed_valid toggling during load -> exactly 89 bits accepted, out_valid rises exactly 160 cycles after the last seed accept.
REQ-037 stop and reset each asserted once in LOAD, WARMUP and RUN -> IDLE next cycle with all outputs at reset values; start on the same cycle as stop is ignored.

Source files
------------

// File: rtl/lfsr_keystream_if.sv
// Control, serial-seed and keystream handshake bundle for lfsr_keystream.
// master drives requests, seed data and out_ready; slave is the generator.
interface lfsr_keystream_if #(
    parameter int unsigned OUT_W = 1
);
    logic             start;
    logic             stop;
    logic             seed_bit;
    logic             seed_valid;
    logic             seed_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             err_zero;

    modport master (
        output start, stop, seed_bit, seed_valid, out_ready,
        input  seed_ready, out_data, out_valid, busy, err_zero
    );

    modport slave (
        input  start, stop, seed_bit, seed_valid, out_ready,
        output seed_ready, out_data, out_valid, busy, err_zero
    );
endinterface

// File: rtl/lfsr_keystream.sv
// Fibonacci LFSR keystream generator: serial seed load, optional warm-up,
// then OUT_W keystream bits per accepted beat with backpressure.
module lfsr_keystream #(
    parameter int unsigned       WIDTH    = 89,
    parameter logic [WIDTH-1:0]  TAP_MASK = WIDTH'(1) | (WIDTH'(1) << 51),
    parameter int unsigned       OUT_W    = 1,
    parameter int unsigned       WARMUP   = 160
) (
    input  logic             clk,
    input  logic             reset,
    lfsr_keystream_if.slave  bus
);

    localparam int unsigned LOAD_CW = $clog2(WIDTH + 1);
    localparam int unsigned WARM_CW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [LOAD_CW-1:0] LOAD_LAST = LOAD_CW'(WIDTH - 1);
    localparam logic [WARM_CW-1:0] WARM_LAST = WARM_CW'((WARMUP > 0) ? WARMUP - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WARMUP, S_RUN} state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   lfsr, lfsr_next, seed_shift;
    logic [LOAD_CW-1:0] load_cnt, load_next;
    logic [WARM_CW-1:0] warm_cnt, warm_next;
    logic               err_next;

    logic               seed_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               err_zero_q;
    logic [OUT_W-1:0]   out_data_q;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] r);
        return {^(r & TAP_MASK), r[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH-1:0] lfsr_adv(input logic [WIDTH-1:0] r);
        logic [WIDTH-1:0] t;
        t = r;
        for (int i = 0; i < int'(OUT_W); i++) t = lfsr_step(t);
        return t;
    endfunction

    // Bit i is the output of the i-th step starting from r.
    function automatic logic [OUT_W-1:0] lfsr_bits(input logic [WIDTH-1:0] r);
        logic [WIDTH-1:0] t;
        logic [OUT_W-1:0] b;
        t = r;
        b = '0;
        for (int i = 0; i < int'(OUT_W); i++) begin
            b[i] = t[0];
            t    = lfsr_step(t);
        end
        return b;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        lfsr_next  = lfsr;
        load_next  = load_cnt;
        warm_next  = warm_cnt;
        err_next   = 1'b0;
        seed_shift = {bus.seed_bit, lfsr[WIDTH-1:1]};

        if (bus.stop) begin
            state_next = S_IDLE;
            lfsr_next  = '0;
            load_next  = '0;
            warm_next  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state_next = S_LOAD;
                        load_next  = '0;
                    end
                end
                S_LOAD: begin
                    if (bus.seed_valid) begin
                        lfsr_next = seed_shift;
                        load_next = load_cnt + LOAD_CW'(1);
                        if (load_cnt == LOAD_LAST) begin
                            load_next = '0;
                            // An all-zero state would lock the LFSR, so reject it.
                            if (seed_shift == '0) begin
                                state_next = S_IDLE;
                                err_next   = 1'b1;
                            end else if (WARMUP == 0) begin
                                state_next = S_RUN;
                            end else begin
                                state_next = S_WARMUP;
                                warm_next  = '0;
                            end
                        end
                    end
                end
                S_WARMUP: begin
                    lfsr_next = lfsr_step(lfsr);
                    if (warm_cnt == WARM_LAST) begin
                        state_next = S_RUN;
                        warm_next  = '0;
                    end else begin
                        warm_next = warm_cnt + WARM_CW'(1);
                    end
                end
                S_RUN: begin
                    if (out_valid_q && bus.out_ready) lfsr_next = lfsr_adv(lfsr);
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Datapath and outputs are registered from the next-state values.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr         <= '0;
            load_cnt     <= '0;
            warm_cnt     <= '0;
            seed_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            err_zero_q   <= 1'b0;
            out_data_q   <= '0;
        end else begin
            lfsr         <= lfsr_next;
            load_cnt     <= load_next;
            warm_cnt     <= warm_next;
            seed_ready_q <= (state_next == S_LOAD);
            out_valid_q  <= (state_next == S_RUN);
            busy_q       <= (state_next != S_IDLE);
            err_zero_q   <= err_next;
            out_data_q   <= (state_next == S_RUN) ? lfsr_bits(lfsr_next) : '0;
        end
    end

    assign bus.seed_ready = seed_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.err_zero   = err_zero_q;
    assign bus.out_data   = out_data_q;

endmodule

// File: tb/tb_lfsr_keystream.sv
// Directed bench for lfsr_keystream: two 4-bit instances (OUT_W 1 and 4) share
// a cycle table; a default-parameter instance covers load counting and warm-up.
module tb_lfsr_keystream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Shared stimulus for the two small instances
    logic ab_rst = 1'b1, a_start = 1'b0, a_stop = 1'b0, a_sb = 1'b0, a_sv = 1'b0, a_ordy = 1'b0;
    // Stimulus for the default instance
    logic c_rst = 1'b1, c_start = 1'b0, c_stop = 1'b0, c_sb = 1'b0, c_sv = 1'b0, c_ordy = 1'b0;

    lfsr_keystream_if #(.OUT_W(1)) if_a ();
    lfsr_keystream_if #(.OUT_W(4)) if_b ();
    lfsr_keystream_if #(.OUT_W(1)) if_c ();

    assign if_a.start = a_start;  assign if_a.stop = a_stop;  assign if_a.seed_bit = a_sb;
    assign if_a.seed_valid = a_sv; assign if_a.out_ready = a_ordy;
    assign if_b.start = a_start;  assign if_b.stop = a_stop;  assign if_b.seed_bit = a_sb;
    assign if_b.seed_valid = a_sv; assign if_b.out_ready = a_ordy;
    assign if_c.start = c_start;  assign if_c.stop = c_stop;  assign if_c.seed_bit = c_sb;
    assign if_c.seed_valid = c_sv; assign if_c.out_ready = c_ordy;

    lfsr_keystream #(.WIDTH(4), .TAP_MASK(4'b0011), .OUT_W(1), .WARMUP(0))
        u_a (.clk(clk), .reset(ab_rst), .bus(if_a));
    lfsr_keystream #(.WIDTH(4), .TAP_MASK(4'b0011), .OUT_W(4), .WARMUP(0))
        u_b (.clk(clk), .reset(ab_rst), .bus(if_b));
    lfsr_keystream u_c (.clk(clk), .reset(c_rst), .bus(if_c));

    typedef struct {
        logic       rst, start, stop, sb, sv, ordy;
        logic       sr, ov, da;
        logic [3:0] db;
        logic       busy, err;
    } vec_t;

    localparam int NV = 41;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic rst, start, stop, sb, sv, ordy,
                                input logic sr, ov, da, input logic [3:0] db,
                                input logic busy, err);
        vec_t v;
        v.rst = rst; v.start = start; v.stop = stop; v.sb = sb; v.sv = sv; v.ordy = ordy;
        v.sr = sr; v.ov = ov; v.da = da; v.db = db; v.busy = busy; v.err = err;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_c_idle(input string name);
        chk({name, "_busy"}, 0, 32'(if_c.busy), 32'd0);
        chk({name, "_sready"}, 0, 32'(if_c.seed_ready), 32'd0);
        chk({name, "_ovalid"}, 0, 32'(if_c.out_valid), 32'd0);
        chk({name, "_data"}, 0, 32'(if_c.out_data), 32'd0);
        chk({name, "_err"}, 0, 32'(if_c.err_zero), 32'd0);
    endtask

    // Load 89 ones back to back, then sit a few cycles inside warm-up.
    task automatic c_load_into_warmup();
        c_start = 1'b1; tick(); c_start = 1'b0;
        c_sv = 1'b1; c_sb = 1'b1;
        for (int i = 0; i < 89; i++) tick();
        c_sv = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("c_warm_busy", 0, 32'(if_c.busy), 32'd1);
        chk("c_warm_ovalid", 0, 32'(if_c.out_valid), 32'd0);
        chk("c_warm_sready", 0, 32'(if_c.seed_ready), 32'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [14:0] exp_seq;
        logic [29:0] got;
        int accepted, guard, wait_cyc;

        //        rst st sp sb sv rd | sr ov da db       bsy err
        vecs[0]  = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 4'b0000, 0, 0);
        vecs[1]  = mk(0, 1, 0, 0, 0, 0,  1, 0, 0, 4'b0000, 1, 0);
        vecs[2]  = mk(0, 0, 0, 1, 1, 0,  1, 0, 0, 4'b0000, 1, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 4'b0000, 1, 0);
        vecs[4]  = mk(0, 0, 0, 0, 1, 0,  1, 0, 0, 4'b0000, 1, 0);
        vecs[5]  = mk(0, 0, 0, 0, 1, 0,  1, 0, 0, 4'b0000, 1, 0);
        vecs[6]  = mk(0, 1, 0, 0, 1, 0,  0, 1, 1, 4'b0001, 1, 0);
        for (int i = 7; i <= 11; i++)
            vecs[i] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 4'b0001, 1, 0);
        vecs[12] = mk(0, 0, 0, 0, 0, 1,  0, 1, 0, 4'b1001, 1, 0);
        vecs[13] = mk(0, 0, 0, 0, 0, 1,  0, 1, 0, 4'b0101, 1, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 1,  0, 1, 0, 4'b1111, 1, 0);
        vecs[15] = mk(0, 0, 0, 0, 0, 1,  0, 1, 1, 4'b1000, 1, 0);
        vecs[16] = mk(0, 0, 0, 0, 0, 1,  0, 1, 0, 4'b1100, 1, 0);
        vecs[17] = mk(0, 0, 0, 0, 0, 1,  0, 1, 0, 4'b1010, 1, 0);
        vecs[18] = mk(0, 0, 0, 0, 0, 1,  0, 1, 1, 4'b0111, 1, 0);
        vecs[19] = mk(0, 1, 1, 0, 0, 1,  0, 0, 0, 4'b0000, 0, 0);
        vecs[20] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 4'b0000, 0, 0);
        vecs[21] = mk(0, 1, 0, 0, 0, 0,  1, 0, 0, 4'b0000, 1, 0);
        for (int i = 22; i <= 24; i++)
            vecs[i] = mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 4'b0000, 1, 0);
        vecs[25] = mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 4'b0000, 0, 1);
        vecs[26] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 4'b0000, 0, 0);
        vecs[27] = mk(0, 1, 0, 0, 0, 0,  1, 0, 0, 4'b0000, 1, 0);
        vecs[28] = mk(0, 0, 0, 1, 1, 0,  1, 0, 0, 4'b0000, 1, 0);
        vecs[29] = mk(0, 0, 1, 1, 1, 0,  0, 0, 0, 4'b0000, 0, 0);
        vecs[30] = mk(0, 0, 0, 1, 1, 0,  0, 0, 0, 4'b0000, 0, 0);
        vecs[31] = mk(0, 1, 0, 0, 0, 0,  1, 0, 0, 4'b0000, 1, 0);
        vecs[32] = mk(1, 1, 0, 1, 1, 0,  0, 0, 0, 4'b0000, 0, 0);
        vecs[33] = mk(0, 0, 0, 1, 1, 0,  0, 0, 0, 4'b0000, 0, 0);
        vecs[34] = mk(0, 1, 0, 0, 0, 0,  1, 0, 0, 4'b0000, 1, 0);
        vecs[35] = mk(0, 0, 0, 1, 1, 0,  1, 0, 0, 4'b0000, 1, 0);
        vecs[36] = mk(0, 0, 0, 0, 1, 0,  1, 0, 0, 4'b0000, 1, 0);
        vecs[37] = mk(0, 0, 0, 0, 1, 0,  1, 0, 0, 4'b0000, 1, 0);
        vecs[38] = mk(0, 0, 0, 0, 1, 0,  0, 1, 1, 4'b0001, 1, 0);
        vecs[39] = mk(1, 0, 1, 0, 0, 1,  0, 0, 0, 4'b0000, 0, 0);
        vecs[40] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 4'b0000, 0, 0);

        for (int i = 0; i < NV; i++) begin
            ab_rst = vecs[i].rst; a_start = vecs[i].start; a_stop = vecs[i].stop;
            a_sb = vecs[i].sb; a_sv = vecs[i].sv; a_ordy = vecs[i].ordy;
            tick();
            chk("a_sready", i, 32'(if_a.seed_ready), 32'(vecs[i].sr));
            chk("a_ovalid", i, 32'(if_a.out_valid),  32'(vecs[i].ov));
            chk("a_data",   i, 32'(if_a.out_data),   32'(vecs[i].da));
            chk("a_busy",   i, 32'(if_a.busy),       32'(vecs[i].busy));
            chk("a_err",    i, 32'(if_a.err_zero),   32'(vecs[i].err));
            chk("b_ovalid", i, 32'(if_b.out_valid),  32'(vecs[i].ov));
            chk("b_data",   i, 32'(if_b.out_data),   32'(vecs[i].db));
            chk("b_err",    i, 32'(if_b.err_zero),   32'(vecs[i].err));
        end
        ab_rst = 1'b0; a_start = 1'b0; a_stop = 1'b0; a_sv = 1'b0; a_sb = 1'b0; a_ordy = 1'b0;

        // Two full periods of the 15-state sequence from seed 0001
        exp_seq = 15'b111_0101_1001_0001;
        a_start = 1'b1; tick(); a_start = 1'b0;
        a_sv = 1'b1;
        for (int i = 0; i < 4; i++) begin a_sb = (i == 0); tick(); end
        a_sv = 1'b0; a_sb = 1'b0;
        a_ordy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            got[i] = if_a.out_data[0];
            tick();
        end
        for (int i = 0; i < 30; i++)
            chk("a_period_bit", i, 32'(got[i]), 32'(exp_seq[i % 15]));
        a_ordy = 1'b0; a_stop = 1'b1; tick(); a_stop = 1'b0;

        // Default instance: 89 accepts with toggling seed_valid, then 160-cycle warm-up
        c_rst = 1'b1; tick(); c_rst = 1'b0;
        chk_c_idle("c_reset");
        c_start = 1'b1; tick(); c_start = 1'b0;
        accepted = 0;
        guard = 0;
        while (if_c.seed_ready && guard < 400) begin
            c_sv = guard[0];
            c_sb = (accepted % 3 == 0);
            if (c_sv) accepted++;
            tick();
            guard++;
        end
        c_sv = 1'b0;
        chk("c_seed_accepts", 0, 32'(accepted), 32'd89);
        wait_cyc = 0;
        while (!if_c.out_valid && wait_cyc < 400) begin
            tick();
            wait_cyc++;
        end
        chk("c_warmup_cycles", 0, 32'(wait_cyc), 32'd160);
        chk("c_run_busy", 0, 32'(if_c.busy), 32'd1);

        // stop with a same-cycle start in RUN, then in WARMUP
        c_stop = 1'b1; c_start = 1'b1; tick(); c_stop = 1'b0; c_start = 1'b0;
        chk_c_idle("c_stop_run");
        c_load_into_warmup();
        c_stop = 1'b1; c_start = 1'b1; tick(); c_stop = 1'b0; c_start = 1'b0;
        chk_c_idle("c_stop_warm");
        tick();
        chk_c_idle("c_stop_warm_after");

        // reset in WARMUP with stop and start asserted alongside
        c_load_into_warmup();
        c_rst = 1'b1; c_stop = 1'b1; c_start = 1'b1; tick();
        c_rst = 1'b0; c_stop = 1'b0; c_start = 1'b0;
        chk_c_idle("c_reset_warm");
        tick();
        chk_c_idle("c_reset_warm_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
